mem_access_unit: RTL

- Load/store unit on the receiving end of the decoder's memory controls (memRead, memWrite, memDataSize, memBitExt).
- Turns a CPU load/store into a handshaked, word-wide access to data RAM or the bus, with byte enables.
- Handles sub-word lane steering, sign/zero extension and alignment checks.
- Stalls the CPU while the access is outstanding.

---
 rtl/mem_access_unit_pkg.sv | 32 +++
 rtl/mem_access_unit_lane.sv | 48 ++++
 rtl/mem_access_unit.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: size/extension codes, FSM encoding and
// the request legality check shared by the load/store path.
package mem_access_unit_pkg;

  localparam logic [1:0] MEM_SZ_WORD = 2'd0;
  localparam logic [1:0] MEM_SZ_HALF = 2'd1;
  localparam logic [1:0] MEM_SZ_BYTE = 2'd2;

  localparam logic MEM_EXT_SIGN = 1'b0;
  localparam logic MEM_EXT_ZERO = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } mau_state_t;

  function automatic logic mem_req_bad(
    input logic [1:0] size,
    input logic [1:0] off
  );
    logic bad;
    case (size)
      MEM_SZ_WORD: bad = (off != 2'd0);
      MEM_SZ_HALF: bad = off[0];
      MEM_SZ_BYTE: bad = 1'b0;
      default:     bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_access_unit_lane.sv
// mem_lane_align: combinational byte-lane steering for stores and
// lane extraction plus sign/zero extension for loads.
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic        ext,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_rep,
  input  logic [31:0] ld_raw,
  output logic [31:0] ld_data
);

  logic [15:0] ld_sh;
  logic        sgn;

  assign ld_sh = 16'(ld_raw >> {off, 3'b000});
  assign sgn   = (ext == MEM_EXT_SIGN);

  always_comb begin
    st_be   = 4'b0000;
    st_rep  = st_data;
    ld_data = 32'h0;
    case (size)
      MEM_SZ_WORD: begin
        st_be   = 4'b1111;
        ld_data = ld_raw;
      end
      MEM_SZ_HALF: begin
        st_be   = 4'b0011 << off;
        st_rep  = {2{st_data[15:0]}};
        ld_data = {{16{sgn & ld_sh[15]}}, ld_sh};
      end
      MEM_SZ_BYTE: begin
        st_be   = 4'b0001 << off;
        st_rep  = {4{st_data[7:0]}};
        ld_data = {{24{sgn & ld_sh[7]}}, ld_sh[7:0]};
      end
      default: begin
        st_be   = 4'b0000;
        ld_data = 32'h0;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: handshaked load/store unit with lane steering.
// Define MEM_TIMEOUT_EN to abort stalled accesses after TIMEOUT cycles.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int MEM_AW  = 10,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic [1:0]        memDataSize,
  input  logic              memBitExt,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              stall,
  output logic              done,
  output logic              align_err,
  output logic              bus_err,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready
);

  mau_state_t state_q, state_d;

  logic [1:0]        size_q, size_d;
  logic [1:0]        off_q, off_d;
  logic              ext_q, ext_d;
  logic              rd_q, rd_d;
  logic              mem_en_q, mem_en_d;
  logic [3:0]        mem_we_q, mem_we_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              align_err_q, align_err_d;
  logic              bus_err_q, bus_err_d;

  logic        req, bad, accept, tmo;
  logic [1:0]  lane_size, lane_off;
  logic [3:0]  st_be;
  logic [31:0] st_rep, ld_data;
  logic        unused_bits;

  assign req    = memRead ^ memWrite;
  assign bad    = (memRead & memWrite)
                | (req & mem_req_bad(memDataSize, addr[1:0]));
  assign accept = (state_q == ST_IDLE) & req & ~bad;
  assign unused_bits = ^addr[31:MEM_AW+2];

  // Store lanes come from the live request, load lanes from the latch.
  assign lane_size = (state_q == ST_IDLE) ? memDataSize : size_q;
  assign lane_off  = (state_q == ST_IDLE) ? addr[1:0] : off_q;

  mem_lane_align u_lane (
    .size    (lane_size),
    .off     (lane_off),
    .ext     (ext_q),
    .st_data (wdata),
    .st_be   (st_be),
    .st_rep  (st_rep),
    .ld_raw  (mem_rdata),
    .ld_data (ld_data)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int CW = (TIMEOUT < 256) ? 8 : $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;

  assign cnt_d = (state_q == ST_WAIT) ? cnt_q + 1'b1 : '0;
  assign tmo   = (state_q == ST_WAIT) & ~mem_ready
               & (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  localparam int unused_timeout = TIMEOUT;
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      size_q      <= '0;
      off_q       <= '0;
      ext_q       <= 1'b0;
      rd_q        <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      align_err_q <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      size_q      <= size_d;
      off_q       <= off_d;
      ext_q       <= ext_d;
      rd_q        <= rd_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      align_err_q <= align_err_d;
      bus_err_q   <= bus_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_WAIT;
      ST_WAIT: if (mem_ready | tmo) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    size_d      = size_q;
    off_d       = off_q;
    ext_d       = ext_q;
    rd_d        = rd_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    align_err_d = 1'b0;
    bus_err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        align_err_d = bad;
        if (accept) begin
          size_d      = memDataSize;
          off_d       = addr[1:0];
          ext_d       = memBitExt;
          rd_d        = memRead;
          mem_en_d    = 1'b1;
          mem_addr_d  = addr[MEM_AW+1:2];
          mem_we_d    = memWrite ? st_be : 4'b0000;
          mem_wdata_d = st_rep;
        end
      end
      ST_WAIT: begin
        if (mem_ready) begin
          mem_en_d = 1'b0;
          mem_we_d = 4'b0000;
          if (rd_q) rdata_d = ld_data;
        end else if (tmo) begin
          mem_en_d  = 1'b0;
          mem_we_d  = 4'b0000;
          bus_err_d = 1'b1;
          rdata_d   = 32'h0;
        end
      end
      default: ;
    endcase
  end

  assign stall     = accept | (state_q == ST_WAIT);
  assign done      = (state_q == ST_DONE);
  assign rdata     = rdata_q;
  assign align_err = align_err_q;
  assign bus_err   = bus_err_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
